// File: rtl/async_event_arbiter.sv
// Asynchronous event arbiter: synchronizes N level requests, turns rising edges into
// pending events and offers them one at a time over a valid/ready port, round-robin.
module async_event_arbiter #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int IDW         = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_async,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overflow,
  input  logic [N-1:0]   clear_overflow
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  logic [N-1:0]   sync_r [SYNC_STAGES];
  logic [N-1:0]   hist_r;
  logic [N-1:0]   pending_r;
  logic [N-1:0]   overflow_r;
  logic [N-1:0]   sync_out_s;
  logic [N-1:0]   edge_s;
  logic [N-1:0]   hs_vec_s;
  logic [N-1:0]   pending_nxt_s;
  logic [N-1:0]   overflow_nxt_s;
  logic [N-1:0]   cand_s;
  logic [IDW-1:0] base_s;
  logic [IDW-1:0] pick_s;
  logic           found_s;
  logic           hs_s;
  logic           evt_valid_s;
  logic [IDW-1:0] ptr_inc_s;
  state_t         state_r;
  state_t         state_nxt_s;
  logic [IDW-1:0] evt_id_r;
  logic [IDW-1:0] evt_id_nxt_s;
  logic [IDW-1:0] ptr_r;
  logic [IDW-1:0] ptr_nxt_s;

  // First set bit of cand at or after base, wrapping modulo N.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] cand, input logic [IDW-1:0] base);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDW:0]   sum;
    dbl = {cand, cand} >> base;
    rot = dbl[N-1:0];
    sum = {1'b0, base};
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = {1'b0, base} + (IDW+1)'(j);
      end
    end
    if (sum >= (IDW+1)'(N)) begin
      sum = sum - (IDW+1)'(N);
    end
    return sum[IDW-1:0];
  endfunction

  // Synchronizer chains and edge-history flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= '0;
      end
      hist_r <= '0;
    end else begin
      sync_r[0] <= req_async;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
      hist_r <= sync_out_s;
    end
  end

  assign sync_out_s = sync_r[SYNC_STAGES-1];
  assign edge_s     = sync_out_s & ~hist_r;
  assign hs_s       = evt_valid_s & evt_ready;
  assign ptr_inc_s  = (evt_id_r == IDW'(N - 1)) ? '0 : evt_id_r + IDW'(1);

  // One-hot of the requester being handshaken this cycle.
  always_comb begin
    hs_vec_s = '0;
    for (int i = 0; i < N; i++) begin
      if (hs_s && (evt_id_r == IDW'(i))) begin
        hs_vec_s[i] = 1'b1;
      end else begin
        hs_vec_s[i] = 1'b0;
      end
    end
  end

  // A new edge keeps a bit pending even when its previous event is being accepted.
  assign pending_nxt_s  = edge_s | (pending_r & ~hs_vec_s);
  assign overflow_nxt_s = (edge_s & pending_r & ~hs_vec_s) | (overflow_r & ~clear_overflow);

  // Pending and overflow flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r  <= '0;
      overflow_r <= '0;
    end else begin
      pending_r  <= pending_nxt_s;
      overflow_r <= overflow_nxt_s;
    end
  end

  // Arbitration candidates: in OFFER the accepted bit is masked and the search restarts after it.
  always_comb begin
    cand_s = pending_r;
    base_s = ptr_r;
    case (state_r)
      ST_IDLE: begin
        cand_s = pending_r;
        base_s = ptr_r;
      end
      ST_OFFER: begin
        cand_s = pending_r & ~hs_vec_s;
        base_s = ptr_inc_s;
      end
      default: begin
        cand_s = pending_r;
        base_s = ptr_r;
      end
    endcase
    found_s = |cand_s;
    pick_s  = rr_pick(cand_s, base_s);
  end

  // FSM state, offered id and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      evt_id_r <= '0;
      ptr_r    <= '0;
    end else begin
      state_r  <= state_nxt_s;
      evt_id_r <= evt_id_nxt_s;
      ptr_r    <= ptr_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s  = state_r;
    evt_id_nxt_s = evt_id_r;
    ptr_nxt_s    = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_nxt_s  = ST_OFFER;
          evt_id_nxt_s = pick_s;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (hs_s) begin
          ptr_nxt_s = ptr_inc_s;
          if (found_s) begin
            state_nxt_s  = ST_OFFER;
            evt_id_nxt_s = pick_s;
          end else begin
            state_nxt_s  = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_OFFER;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: evt_valid is a direct decode of the state flop.
  always_comb begin
    evt_valid_s = 1'b0;
    case (state_r)
      ST_IDLE:  evt_valid_s = 1'b0;
      ST_OFFER: evt_valid_s = 1'b1;
      default:  evt_valid_s = 1'b0;
    endcase
  end

  assign evt_valid = evt_valid_s;
  assign evt_id    = evt_id_r;
  assign pending   = pending_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_async_event_arbiter.sv
// Bench for async_event_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a cycle-level reference model of the event rules.
module tb_async_event_arbiter;
  localparam int N   = 4;
  localparam int SS  = 2;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_async = '0;
  logic           evt_valid;
  logic           evt_ready = 1'b0;
  logic [IDW-1:0] evt_id;
  logic [N-1:0]   pending;
  logic [N-1:0]   overflow;
  logic [N-1:0]   clear_overflow = '0;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: samples of req_async (q[0] newest), pending, overflow, offer.
  bit [N-1:0] q [SS+1];
  bit         m_valid;
  int         m_id;
  int         m_ptr;
  bit [N-1:0] m_pend;
  bit [N-1:0] m_ovf;

  always #5 clk = ~clk;

  async_event_arbiter #(.N(N), .SYNC_STAGES(SS), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_async(req_async), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_id(evt_id), .pending(pending),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  function automatic int pick(input bit [N-1:0] p, input int base);
    for (int k = 0; k < N; k++) begin
      if (p[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic step();
    bit [N-1:0] edg, hsv, msk;
    bit hs;
    int c;
    if (rst) begin
      for (int s = 0; s <= SS; s++) q[s] = '0;
      m_valid = 1'b0; m_id = 0; m_ptr = 0; m_pend = '0; m_ovf = '0;
    end else begin
      edg = q[SS-1] & ~q[SS];
      hs  = m_valid && evt_ready;
      hsv = '0;
      if (hs) hsv[m_id] = 1'b1;
      if (!m_valid) begin
        c = pick(m_pend, m_ptr);
        if (c >= 0) begin m_valid = 1'b1; m_id = c; end
      end else if (hs) begin
        m_ptr = (m_id + 1) % N;
        msk = m_pend;
        msk[m_id] = 1'b0;
        c = pick(msk, m_ptr);
        if (c >= 0) m_id = c;
        else m_valid = 1'b0;
      end
      m_ovf  = (edg & m_pend & ~hsv) | (m_ovf & ~clear_overflow);
      m_pend = edg | (m_pend & ~hsv);
      for (int s = SS; s > 0; s--) q[s] = q[s-1];
      q[0] = req_async;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_async = '0; evt_ready = 1'b0; clear_overflow = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_async = 4'hF; evt_ready = 1'b1;
    step(); step();
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", evt_valid); else n_pass++;
    n_checks++; if (evt_id !== 2'd0) $display("FAIL reset_id got %0d want 0", evt_id); else n_pass++;
    n_checks++; if (pending !== 4'h0) $display("FAIL reset_pending got %b want 0000", pending); else n_pass++;
    n_checks++; if (overflow !== 4'h0) $display("FAIL reset_overflow got %b want 0000", overflow); else n_pass++;
    req_async = '0; evt_ready = 1'b0; rst = 1'b0;
  endtask

  task automatic test_latency();
    int hs_cnt = 0;
    do_reset();
    step();
    req_async = 4'b0100; evt_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (evt_valid && evt_ready) hs_cnt++;
      step();
      n_checks++; if (evt_valid !== (k == 4)) $display("FAIL lat_valid edge %0d got %b want %b", k, evt_valid, (k == 4)); else n_pass++;
      if (k == 3) begin
        n_checks++; if (pending !== 4'b0100) $display("FAIL lat_pending got %b want 0100", pending); else n_pass++;
      end
      if (k == 4) begin
        n_checks++; if (evt_id !== 2'd2) $display("FAIL lat_id got %0d want 2", evt_id); else n_pass++;
      end
      n_checks++; if (evt_valid !== m_valid || evt_id !== IDW'(m_id) || pending !== m_pend || overflow !== m_ovf) $display("FAIL lat_model v=%b id=%0d p=%b o=%b want v=%b id=%0d p=%b o=%b", evt_valid, evt_id, pending, overflow, m_valid, m_id, m_pend, m_ovf); else n_pass++;
    end
    n_checks++; if (hs_cnt !== 1) $display("FAIL lat_handshakes got %0d want 1", hs_cnt); else n_pass++;
    n_checks++; if (pending !== 4'h0) $display("FAIL lat_pending_end got %b want 0000", pending); else n_pass++;
    req_async = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    evt_ready = 1'b1; req_async = 4'hF;
    for (int t = 0; t < 10 && !evt_valid; t++) step();
    for (int j = 0; j < N; j++) begin
      n_checks++; if (evt_valid !== 1'b1 || evt_id !== IDW'(j)) $display("FAIL b2b_slot%0d got v=%b id=%0d want v=1 id=%0d", j, evt_valid, evt_id, j); else n_pass++;
      step();
    end
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL b2b_idle got %b want 0", evt_valid); else n_pass++;
    n_checks++; if (evt_valid !== m_valid || evt_id !== IDW'(m_id) || pending !== m_pend || overflow !== m_ovf) $display("FAIL b2b_model v=%b id=%0d p=%b want v=%b id=%0d p=%b", evt_valid, evt_id, pending, m_valid, m_id, m_pend); else n_pass++;
    req_async = '0;
  endtask

  task automatic test_overflow();
    int hs_cnt = 0;
    do_reset();
    req_async = 4'b0010;
    for (int t = 0; t < 10 && !evt_valid; t++) step();
    for (int t = 0; t < 10; t++) begin
      if (t == 1) req_async = 4'b0000;
      if (t == 5) req_async = 4'b0010;
      step();
      n_checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) $display("FAIL ovf_hold t=%0d got v=%b id=%0d want v=1 id=1", t, evt_valid, evt_id); else n_pass++;
      n_checks++; if (evt_valid !== m_valid || evt_id !== IDW'(m_id) || pending !== m_pend || overflow !== m_ovf) $display("FAIL ovf_model p=%b o=%b want p=%b o=%b", pending, overflow, m_pend, m_ovf); else n_pass++;
    end
    n_checks++; if (overflow !== 4'b0010) $display("FAIL ovf_set got %b want 0010", overflow); else n_pass++;
    evt_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (evt_valid && evt_ready) hs_cnt++;
      step();
    end
    n_checks++; if (hs_cnt !== 1) $display("FAIL ovf_handshakes got %0d want 1", hs_cnt); else n_pass++;
    n_checks++; if (pending !== 4'h0) $display("FAIL ovf_pending got %b want 0000", pending); else n_pass++;
    clear_overflow = 4'b0010;
    step();
    clear_overflow = '0;
    n_checks++; if (overflow !== 4'h0) $display("FAIL ovf_clear got %b want 0000", overflow); else n_pass++;
    req_async = '0; evt_ready = 1'b0;
  endtask

  task automatic test_edge_on_handshake();
    do_reset();
    req_async = 4'b0001;
    for (int t = 0; t < 10 && !evt_valid; t++) step();
    req_async = 4'b0000;
    repeat (4) step();
    req_async = 4'b0001;
    step(); step();
    evt_ready = 1'b1;
    step();
    n_checks++; if (pending[0] !== 1'b1) $display("FAIL eoh_pending got %b want 1", pending[0]); else n_pass++;
    n_checks++; if (overflow[0] !== 1'b0) $display("FAIL eoh_overflow got %b want 0", overflow[0]); else n_pass++;
    n_checks++; if (evt_valid !== m_valid || evt_id !== IDW'(m_id) || pending !== m_pend || overflow !== m_ovf) $display("FAIL eoh_model v=%b p=%b want v=%b p=%b", evt_valid, pending, m_valid, m_pend); else n_pass++;
    step();
    n_checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd0) $display("FAIL eoh_reoffer got v=%b id=%0d want v=1 id=0", evt_valid, evt_id); else n_pass++;
    step();
    n_checks++; if (pending !== 4'h0) $display("FAIL eoh_drained got %b want 0000", pending); else n_pass++;
    req_async = '0; evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    req_async = 4'b1000;
    for (int t = 0; t < 10 && !evt_valid; t++) step();
    n_checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd3) $display("FAIL rmo_offer got v=%b id=%0d want v=1 id=3", evt_valid, evt_id); else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (evt_valid !== 1'b0 || pending !== 4'h0) $display("FAIL rmo_dropped got v=%b p=%b want v=0 p=0000", evt_valid, pending); else n_pass++;
    for (int k = 1; k <= SS + 2; k++) begin
      step();
      n_checks++; if (evt_valid !== (k == SS + 2)) $display("FAIL rmo_relatency edge %0d got %b want %b", k, evt_valid, (k == SS + 2)); else n_pass++;
    end
    n_checks++; if (evt_id !== 2'd3) $display("FAIL rmo_id got %0d want 3", evt_id); else n_pass++;
    req_async = '0;
  endtask

  task automatic test_fairness_random();
    int grants[$];
    bit [N-1:0] seen;
    bit held;
    logic [IDW-1:0] held_id;
    do_reset();
    for (int c = 0; c < 200; c++) begin
      req_async = (c % 2 == 0) ? 4'hF : 4'h0;
      evt_ready = 1'($urandom_range(0, 1));
      held = evt_valid && !evt_ready;
      held_id = evt_id;
      if (evt_valid && evt_ready) grants.push_back(int'(evt_id));
      step();
      if (held) begin
        n_checks++; if (evt_valid !== 1'b1 || evt_id !== held_id) $display("FAIL fair_stable got v=%b id=%0d want v=1 id=%0d", evt_valid, evt_id, held_id); else n_pass++;
      end
      n_checks++; if (evt_valid !== m_valid || evt_id !== IDW'(m_id) || pending !== m_pend || overflow !== m_ovf) $display("FAIL fair_model c=%0d v=%b id=%0d p=%b o=%b want v=%b id=%0d p=%b o=%b", c, evt_valid, evt_id, pending, overflow, m_valid, m_id, m_pend, m_ovf); else n_pass++;
    end
    for (int w = 0; w + N <= grants.size(); w += N) begin
      seen = '0;
      for (int k = 0; k < N; k++) seen[grants[w+k]] = 1'b1;
      n_checks++; if (seen !== 4'hF) $display("FAIL fair_window %0d got %b want 1111", w / N, seen); else n_pass++;
    end
    for (int c = 0; c < 150; c++) begin
      req_async = N'($urandom);
      evt_ready = 1'($urandom_range(0, 1));
      clear_overflow = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step();
      n_checks++; if (evt_valid !== m_valid || evt_id !== IDW'(m_id) || pending !== m_pend || overflow !== m_ovf) $display("FAIL rand_model c=%0d v=%b id=%0d p=%b o=%b want v=%b id=%0d p=%b o=%b", c, evt_valid, evt_id, pending, overflow, m_valid, m_id, m_pend, m_ovf); else n_pass++;
    end
    req_async = '0; evt_ready = 1'b0; clear_overflow = '0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_overflow();
    test_edge_on_handshake();
    test_reset_mid_offer();
    test_fairness_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/async_event_arbiter.md
ASYNC_EVENT_ARBITER -- requirements
Module: async_event_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of asynchronous requesters; legal range 2..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per request bit; legal range 2..4.
REQ-003 SHALL have parameter IDW, default $clog2(N): width of evt_id.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_async  input  N  asynchronous level requests; rising edge of bit i is one event from requester i.
REQ-007 SHALL have port evt_valid  output  1  event offered, registered.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts offered event.
REQ-009 SHALL have port evt_id  output  IDW  index of offered requester, registered.
REQ-010 SHALL have port pending  output  N  registered per-requester pending flags.
REQ-011 SHALL have port overflow  output  N  sticky flags: event lost while already pending.
REQ-012 SHALL have port clear_overflow  input  N  per-bit clear of overflow.

Function
REQ-013 SHALL pass each req_async bit through an independent SYNC_STAGES-deep flop chain; no logic between chain stages.
REQ-014 SHALL keep one history flop per bit after the chain; edge[i] = sync[i] & ~hist[i]; falling edges ignored.
REQ-015 SHALL set pending[i] on the edge after edge[i] is high.
REQ-016 SHALL clear pending[i] on the edge after a handshake (evt_valid & evt_ready) with evt_id==i, unless edge[i] is high that cycle, in which case pending[i] stays 1 and no overflow.
REQ-017 SHALL set overflow[i] when edge[i] is high, pending[i] is 1 and bit i is not being handshaken; the event is dropped.
REQ-018 SHALL clear overflow[i] when clear_overflow[i] is high; a simultaneous set takes priority.
REQ-019 SHALL implement a two-state FSM: IDLE (evt_valid=0) and OFFER (evt_valid=1).
REQ-020 IDLE: if any pending bit is 1, SHALL select the first set bit searching ptr, ptr+1, ... mod N, load evt_id, go to OFFER; else stay IDLE.
REQ-021 OFFER: SHALL hold evt_valid and evt_id stable while evt_ready is 0.
REQ-022 OFFER with handshake: ptr SHALL become (evt_id+1) mod N; arbitration over pending with bit evt_id masked SHALL run same cycle; if a candidate exists, stay OFFER with new evt_id (back-to-back, no bubble), else go IDLE.
REQ-023 Arbitration SHALL use only registered pending; edges in cycle t are eligible from cycle t+1.
REQ-024 Latency: with req_async stable high before sampling edge E, pending SHALL rise after edge E+SYNC_STAGES and evt_valid after edge E+SYNC_STAGES+1, when FSM idle and no other pending.
REQ-025 Fairness: with all N continuously pending and evt_ready=1, SHALL grant each requester exactly once per N consecutive handshakes.
REQ-026 evt_ready while evt_valid=0 SHALL have no effect.

Reset
REQ-027 While rst is high at a rising edge: sync chains, hist, pending, overflow SHALL clear to 0, ptr to 0, FSM to IDLE, evt_valid to 0, evt_id to 0.
REQ-028 Reset mid-offer SHALL drop the offered and all pending events without handshake.
REQ-029 A req_async bit high across reset release SHALL be treated as a new rising edge after release.

Verification
REQ-030 N=4, SYNC_STAGES=2: raise req_async[2] 1 cycle after reset, evt_ready=1 -> evt_valid high exactly after 4th edge from sampling, evt_id=2, single handshake, pending=0.
REQ-031 All 4 bits rise together, evt_ready=1 -> ids 0,1,2,3 on 4 consecutive cycles, no bubbles, then evt_valid=0.
REQ-032 Bit 1 event, evt_ready=0 for 10 cycles, second pulse on bit 1 (low 4 cycles, high again) -> evt_id stays 1, overflow[1]=1, one handshake only; clear_overflow[1] -> overflow[1]=0.
REQ-033 New bit-0 edge in same cycle as handshake of id 0 -> pending[0] remains 1, overflow[0]=0, second offer of id 0 follows.
REQ-034 rst asserted during OFFER with req_async[3] held high -> evt_valid=0 after reset edge; after release, id 3 offered again after SYNC_STAGES+2 edges.
REQ-035 Continuous pending on all bits, random evt_ready -> every id granted once per 4 handshakes; evt_id never changes while evt_valid & ~evt_ready.
